// File: rtl/vc_pkg.sv
// Shared types and helpers for the victim-cache controller.
package vc_pkg;

   // Tags are stored at the widest supported address width; unused upper bits stay zero.
   localparam int unsigned MAX_ADDR_W = 64;

   typedef logic [MAX_ADDR_W-1:0] tag_t;

   typedef enum logic [2:0] {
      IDLE,
      READ_HIT,
      PMEM_READ,
      EVICT_WB,
      INSTALL,
      FLUSH_SCAN,
      FLUSH_WB,
      FLUSH_DONE
   } state_t;

   // Tag of a byte address.
   function automatic tag_t addr_tag(input logic [MAX_ADDR_W-1:0] addr,
                                     input int unsigned offset_w);
      return addr >> offset_w;
   endfunction

   // Line-aligned address rebuilt from a tag.
   function automatic logic [MAX_ADDR_W-1:0] line_addr(input tag_t tag,
                                                       input int unsigned offset_w);
      return tag << offset_w;
   endfunction

endpackage

// File: rtl/vc_lru_ages.sv
// True-LRU tracker: one age counter per entry, kept as a permutation 0..N-1.
module vc_lru_ages #(
   parameter  int unsigned NUM_ENTRIES = 4,
   localparam int unsigned WAY_W       = $clog2(NUM_ENTRIES)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         touch,
   input  logic [WAY_W-1:0]             touch_way,
   output logic [WAY_W-1:0]             lru_way,
   output logic [NUM_ENTRIES*WAY_W-1:0] ages
);

   logic [WAY_W-1:0] age_q [NUM_ENTRIES];

   // Touched entry becomes age 0; entries younger than it age by one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ENTRIES; i++) age_q[i] <= WAY_W'(i);
      end else if (touch) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (WAY_W'(i) == touch_way)            age_q[i] <= '0;
            else if (age_q[i] < age_q[touch_way])  age_q[i] <= age_q[i] + WAY_W'(1);
         end
      end
   end

   // Oldest entry and flattened age vector.
   always_comb begin
      lru_way = '0;
      ages    = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         ages[i*WAY_W +: WAY_W] = age_q[i];
         if (age_q[i] == WAY_W'(NUM_ENTRIES-1)) lru_way = WAY_W'(i);
      end
   end

endmodule

// File: rtl/cache_control_vc_nway.sv
// Fully-associative victim-cache controller between L2 and physical memory.
module cache_control_vc_nway
   import vc_pkg::*;
#(
   parameter  int unsigned ADDR_W      = 32,
   parameter  int unsigned OFFSET_W    = 5,
   parameter  int unsigned NUM_ENTRIES = 4,
   localparam int unsigned WAY_W       = $clog2(NUM_ENTRIES)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] mem_address,
   input  logic              mem_dirty,
   input  logic              flush,
   input  logic              pmem_resp,
   output logic              mem_resp,
   output logic              rdatamux_sel,
   output logic [WAY_W-1:0]  way_sel,
   output logic              load_entry,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic              flush_done,
   output logic              busy
);

   state_t                   state_q, state_d;
   tag_t                     tag_q [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0]   valid_q, dirty_q;
   logic [WAY_W-1:0]         target_q, target_d;
   logic [WAY_W-1:0]         idx_q, idx_d;
   tag_t                     req_tag_q;
   logic                     hit_q;
   logic                     ins_dirty_q;

   tag_t                     req_tag;
   logic                     hit;
   logic [WAY_W-1:0]         hit_way;
   logic                     has_invalid;
   logic [WAY_W-1:0]         invalid_way;
   logic [WAY_W-1:0]         write_way;
   logic [WAY_W-1:0]         lru_way;
   logic [NUM_ENTRIES*WAY_W-1:0] ages;
   logic [WAY_W-1:0]         age_arr [NUM_ENTRIES];

   localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(NUM_ENTRIES-1);

   vc_lru_ages #(
      .NUM_ENTRIES (NUM_ENTRIES)
   ) u_lru (
      .clk       (clk),
      .rst_n     (rst_n),
      .touch     (state_q == INSTALL),
      .touch_way (target_q),
      .lru_way   (lru_way),
      .ages      (ages)
   );

   // Tag match and lowest-index invalid entry for the current request.
   always_comb begin
      req_tag     = addr_tag(MAX_ADDR_W'(mem_address), OFFSET_W);
      hit         = 1'b0;
      hit_way     = '0;
      has_invalid = 1'b0;
      invalid_way = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (valid_q[i] && (tag_q[i] == req_tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(i);
         end
      end
      for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            has_invalid = 1'b1;
            invalid_way = WAY_W'(i);
         end
      end
      if (hit)              write_way = hit_way;
      else if (has_invalid) write_way = invalid_way;
      else                  write_way = lru_way;
   end

   // Next-state, target and flush-index selection.
   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      idx_d    = idx_q;
      case (state_q)
         IDLE: begin
            if (mem_write) begin
               target_d = write_way;
               if (valid_q[write_way] && dirty_q[write_way] && !hit) state_d = EVICT_WB;
               else                                                  state_d = INSTALL;
            end else if (mem_read) begin
               target_d = hit_way;
               state_d  = hit ? READ_HIT : PMEM_READ;
            end else if (flush) begin
               idx_d   = '0;
               state_d = FLUSH_SCAN;
            end
         end
         READ_HIT:  state_d = IDLE;
         PMEM_READ: if (pmem_resp) state_d = IDLE;
         EVICT_WB:  if (pmem_resp) state_d = INSTALL;
         INSTALL:   state_d = IDLE;
         FLUSH_SCAN: begin
            if (valid_q[idx_q] && dirty_q[idx_q]) state_d = FLUSH_WB;
            else if (idx_q == LAST_WAY)           state_d = FLUSH_DONE;
            else                                  idx_d   = idx_q + WAY_W'(1);
         end
         FLUSH_WB: begin
            if (pmem_resp) state_d = (idx_q == LAST_WAY) ? FLUSH_DONE : FLUSH_SCAN;
         end
         FLUSH_DONE: state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   // State register plus request context captured while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         target_q    <= '0;
         idx_q       <= '0;
         req_tag_q   <= '0;
         hit_q       <= 1'b0;
         ins_dirty_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         idx_q    <= idx_d;
         if (state_q == IDLE) begin
            req_tag_q   <= req_tag;
            hit_q       <= hit;
            ins_dirty_q <= mem_dirty;
         end
      end
   end

   // Entry tag/valid/dirty bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
         for (int i = 0; i < NUM_ENTRIES; i++) tag_q[i] <= '0;
      end else begin
         case (state_q)
            READ_HIT: begin
               valid_q[target_q] <= 1'b0;
               dirty_q[target_q] <= 1'b0;
            end
            EVICT_WB: if (pmem_resp) dirty_q[target_q] <= 1'b0;
            INSTALL: begin
               tag_q[target_q]   <= req_tag_q;
               valid_q[target_q] <= 1'b1;
               dirty_q[target_q] <= ins_dirty_q | (hit_q & dirty_q[target_q]);
            end
            FLUSH_WB: if (pmem_resp) dirty_q[idx_q] <= 1'b0;
            default: ;
         endcase
      end
   end

   // Moore output decode; mem_resp in PMEM_READ follows pmem_resp.
   always_comb begin
      mem_resp     = 1'b0;
      rdatamux_sel = 1'b0;
      way_sel      = '0;
      load_entry   = 1'b0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      flush_done   = 1'b0;
      busy         = (state_q != IDLE);
      case (state_q)
         READ_HIT: begin
            way_sel      = target_q;
            rdatamux_sel = 1'b1;
            mem_resp     = 1'b1;
         end
         PMEM_READ: begin
            pmem_read    = 1'b1;
            pmem_address = ADDR_W'(line_addr(req_tag_q, OFFSET_W));
            mem_resp     = pmem_resp;
         end
         EVICT_WB: begin
            pmem_write   = 1'b1;
            way_sel      = target_q;
            pmem_address = ADDR_W'(line_addr(tag_q[target_q], OFFSET_W));
         end
         INSTALL: begin
            load_entry = 1'b1;
            way_sel    = target_q;
            mem_resp   = 1'b1;
         end
         FLUSH_WB: begin
            pmem_write   = 1'b1;
            way_sel      = idx_q;
            pmem_address = ADDR_W'(line_addr(tag_q[idx_q], OFFSET_W));
         end
         FLUSH_DONE: flush_done = 1'b1;
         default: ;
      endcase
   end

   // The reported LRU way must always carry the oldest age.
   always_comb begin
      for (int i = 0; i < NUM_ENTRIES; i++) age_arr[i] = ages[i*WAY_W +: WAY_W];
   end

   lru_consistent: assert property (@(posedge clk) disable iff (!rst_n)
      age_arr[lru_way] == LAST_WAY);

endmodule

// File: tb/tb_cache_control_vc_nway.sv
// Directed + random bench for the victim-cache controller with a queue-based reference model.
module tb_cache_control_vc_nway;

   localparam int ADDR_W   = 32;
   localparam int OFFSET_W = 5;
   localparam int N        = 4;
   localparam int WAY_W    = 2;
   localparam int BUDGET   = 60;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              mem_read, mem_write, mem_dirty, flush, pmem_resp;
   logic [ADDR_W-1:0] mem_address;
   logic              mem_resp, rdatamux_sel, load_entry, pmem_read, pmem_write, flush_done, busy;
   logic [WAY_W-1:0]  way_sel;
   logic [ADDR_W-1:0] pmem_address;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cache_control_vc_nway #(
      .ADDR_W      (ADDR_W),
      .OFFSET_W    (OFFSET_W),
      .NUM_ENTRIES (N)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_address  (mem_address),
      .mem_dirty    (mem_dirty),
      .flush        (flush),
      .pmem_resp    (pmem_resp),
      .mem_resp     (mem_resp),
      .rdatamux_sel (rdatamux_sel),
      .way_sel      (way_sel),
      .load_entry   (load_entry),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .flush_done   (flush_done),
      .busy         (busy)
   );

   // Reference model: entry contents plus a recency list (front = MRU, back = LRU).
   logic [ADDR_W-1:0] m_line  [N];
   bit                m_valid [N];
   bit                m_dirty [N];
   int                m_order [$];

   // Observations collected while serving one request.
   logic [ADDR_W-1:0] log_addr [$];
   logic [WAY_W-1:0]  log_way  [$];
   bit                log_w    [$];
   int                pr_cycles, pw_cycles, wait_left;
   bit                in_txn;
   bit                r_done, r_rdm, r_load;
   logic [WAY_W-1:0]  r_way;
   int                r_cyc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
   endfunction

   task automatic model_reset();
      m_order = {};
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 0;
         m_dirty[i] = 0;
         m_line[i]  = '0;
         m_order.push_back(i);
      end
   endtask

   task automatic model_lookup(input logic [ADDR_W-1:0] ln, output bit hit, output int way);
      hit = 0;
      way = -1;
      for (int i = 0; i < N; i++)
         if (m_valid[i] && m_line[i] == ln) begin hit = 1; way = i; end
   endtask

   task automatic model_wtarget(input logic [ADDR_W-1:0] ln, output bit hit, output int tgt);
      model_lookup(ln, hit, tgt);
      if (!hit) begin
         for (int i = N-1; i >= 0; i--) if (!m_valid[i]) tgt = i;
         if (tgt < 0) tgt = m_order[$];
      end
   endtask

   task automatic model_touch(input int w);
      for (int k = 0; k < m_order.size(); k++)
         if (m_order[k] == w) begin m_order.delete(k); break; end
      m_order.push_front(w);
   endtask

   // Physical-memory responder: one step per cycle, random 0..3 wait states per transfer.
   task automatic pmem_step();
      pmem_resp = 1'b0;
      if (pmem_read || pmem_write) begin
         if (pmem_read)  pr_cycles++;
         if (pmem_write) pw_cycles++;
         if (!in_txn) begin
            in_txn = 1;
            log_addr.push_back(pmem_address);
            log_way.push_back(way_sel);
            log_w.push_back(pmem_write);
            wait_left = $urandom_range(0, 3);
         end
         if (wait_left == 0) begin pmem_resp = 1'b1; in_txn = 0; end
         else wait_left--;
      end
   endtask

   task automatic clear_logs();
      log_addr = {}; log_way = {}; log_w = {};
      pr_cycles = 0; pw_cycles = 0; in_txn = 0;
   endtask

   // Present one L2 request, serve pmem, wait for mem_resp, then drop it in the following idle cycle.
   task automatic run_req(input bit we, input bit re, input logic [ADDR_W-1:0] addr, input bit d);
      clear_logs();
      r_done = 0; r_cyc = 0; r_rdm = 0; r_load = 0; r_way = '0;
      mem_write = we; mem_read = re; mem_address = addr; mem_dirty = d;
      for (int c = 1; c <= BUDGET && !r_done; c++) begin
         @(posedge clk); #1;
         pmem_step();
         #1;
         if (mem_resp) begin
            r_done = 1; r_cyc = c; r_rdm = rdatamux_sel; r_way = way_sel; r_load = load_entry;
         end
      end
      @(posedge clk); #1;
      pmem_resp = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
      chk("idle_after_resp", 64'(busy), 64'd0);
   endtask

   task automatic do_write(input logic [ADDR_W-1:0] addr, input bit d, input bit rd_too);
      logic [ADDR_W-1:0] ln, wb;
      bit hit, ev;
      int tgt;
      ln = line_of(addr);
      model_wtarget(ln, hit, tgt);
      ev = !hit && m_valid[tgt] && m_dirty[tgt];
      wb = m_line[tgt];
      run_req(1'b1, rd_too, addr, d);
      chk("wr_timeout", 64'(r_done), 64'd1);
      chk("wr_load", 64'(r_load), 64'd1);
      chk("wr_rdm", 64'(r_rdm), 64'd0);
      chk("wr_way", 64'(r_way), 64'(tgt));
      chk("wr_npmem", 64'(log_addr.size()), ev ? 64'd1 : 64'd0);
      if (ev && log_addr.size() > 0) begin
         chk("wr_wb_addr", 64'(log_addr[0]), 64'(wb));
         chk("wr_wb_way", 64'(log_way[0]), 64'(tgt));
         chk("wr_wb_isw", 64'(log_w[0]), 64'd1);
         chk("wr_lat_evict", 64'(r_cyc), 64'(pw_cycles + 1));
      end else begin
         chk("wr_lat", 64'(r_cyc), 64'd1);
      end
      m_dirty[tgt] = d | (hit & m_dirty[tgt]);
      m_valid[tgt] = 1;
      m_line[tgt]  = ln;
      model_touch(tgt);
   endtask

   task automatic do_read(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] ln;
      bit hit;
      int way;
      ln = line_of(addr);
      model_lookup(ln, hit, way);
      run_req(1'b0, 1'b1, addr, 1'b0);
      chk("rd_timeout", 64'(r_done), 64'd1);
      chk("rd_load", 64'(r_load), 64'd0);
      chk("rd_rdm", 64'(r_rdm), hit ? 64'd1 : 64'd0);
      if (hit) begin
         chk("rd_hit_way", 64'(r_way), 64'(way));
         chk("rd_hit_npmem", 64'(log_addr.size()), 64'd0);
         chk("rd_hit_lat", 64'(r_cyc), 64'd1);
         m_valid[way] = 0;
         m_dirty[way] = 0;
      end else begin
         chk("rd_miss_npmem", 64'(log_addr.size()), 64'd1);
         if (log_addr.size() > 0) begin
            chk("rd_miss_addr", 64'(log_addr[0]), 64'(ln));
            chk("rd_miss_isw", 64'(log_w[0]), 64'd0);
         end
         chk("rd_miss_lat", 64'(r_cyc), 64'(pr_cycles));
      end
   endtask

   task automatic do_flush();
      logic [ADDR_W-1:0] exp_a [$];
      int exp_w [$];
      bit done;
      for (int i = 0; i < N; i++) begin
         if (m_valid[i] && m_dirty[i]) begin
            exp_a.push_back(m_line[i]);
            exp_w.push_back(i);
            m_dirty[i] = 0;
         end
      end
      clear_logs();
      done  = 0;
      flush = 1'b1;
      for (int c = 0; c < 2*BUDGET && !done; c++) begin
         @(posedge clk); #1;
         pmem_step();
         if (flush_done) begin done = 1; flush = 1'b0; end
      end
      chk("fl_timeout", 64'(done), 64'd1);
      chk("fl_nwb", 64'(log_addr.size()), 64'(exp_a.size()));
      for (int k = 0; k < exp_a.size() && k < log_addr.size(); k++) begin
         chk("fl_wb_addr", 64'(log_addr[k]), 64'(exp_a[k]));
         chk("fl_wb_way", 64'(log_way[k]), 64'(exp_w[k]));
         chk("fl_wb_isw", 64'(log_w[k]), 64'd1);
      end
      flush = 1'b0;
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      chk("fl_done_single", 64'(flush_done), 64'd0);
      chk("fl_idle", 64'(busy), 64'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mem_resp"}, 64'(mem_resp), 64'd0);
      chk({tag, "_rdm"}, 64'(rdatamux_sel), 64'd0);
      chk({tag, "_way"}, 64'(way_sel), 64'd0);
      chk({tag, "_load"}, 64'(load_entry), 64'd0);
      chk({tag, "_pmem_read"}, 64'(pmem_read), 64'd0);
      chk({tag, "_pmem_write"}, 64'(pmem_write), 64'd0);
      chk({tag, "_pmem_addr"}, 64'(pmem_address), 64'd0);
      chk({tag, "_flush_done"}, 64'(flush_done), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      bit hit;
      int tgt;
      logic [ADDR_W-1:0] a;

      rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_dirty = 1'b0;
      flush = 1'b0; pmem_resp = 1'b0; mem_address = '0;
      model_reset();
      #1;
      chk_all_zero("reset");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Clean insert into an empty cache, then hit (invalidating) and miss.
      do_write(32'h1000, 1'b0, 1'b0);
      chk("first_insert_way0", 64'(r_way), 64'd0);
      do_read(32'h1000);
      chk("read_hit_way0", 64'(r_way), 64'd0);
      do_read(32'h1008);

      // Fill with dirty lines and evict the LRU one.
      do_write(32'h0000, 1'b1, 1'b0);
      do_write(32'h0020, 1'b1, 1'b0);
      do_write(32'h0040, 1'b1, 1'b0);
      do_write(32'h0060, 1'b1, 1'b0);
      do_write(32'h0080, 1'b1, 1'b0);
      if (log_addr.size() > 0) chk("evict_line0", 64'(log_addr[0]), 64'h0000);
      do_write(32'h00A0, 1'b1, 1'b0);
      if (log_addr.size() > 0) chk("lru_holds_0020", 64'(log_addr[0]), 64'h0020);

      // Reset in the middle of a stalled writeback.
      model_wtarget(line_of(32'h00C0), hit, tgt);
      mem_write = 1'b1; mem_address = 32'h00C0; mem_dirty = 1'b1; pmem_resp = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      chk("stall_pmem_write", 64'(pmem_write), 64'd1);
      chk("stall_addr", 64'(pmem_address), 64'(m_line[tgt]));
      chk("stall_way", 64'(way_sel), 64'(tgt));
      rst_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      mem_write = 1'b0; mem_dirty = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      do_read(32'h0020);
      chk("post_reset_miss", 64'(r_rdm), 64'd0);

      // Ways 1 and 3 dirty, then flush.
      do_write(32'h0100, 1'b0, 1'b0);
      do_write(32'h0120, 1'b1, 1'b0);
      do_write(32'h0140, 1'b0, 1'b0);
      do_write(32'h0160, 1'b1, 1'b0);
      do_flush();
      do_read(32'h0120);
      chk("hit_after_flush", 64'(r_rdm), 64'd1);

      // Write and read together: write first, read next.
      do_write(32'h0200, 1'b0, 1'b1);
      do_read(32'h0140);

      // Random traffic over a small line pool.
      for (int n = 0; n < 150; n++) begin
         int r;
         r = $urandom_range(0, 99);
         a = 32'h4000 | (32'($urandom_range(0, 7)) << OFFSET_W) | 32'($urandom_range(0, 31));
         if (r < 45)      do_write(a, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
         else if (r < 90) do_read(a);
         else             do_flush();
      end
      do_flush();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
